// File: rtl/vga_pkg.sv
// Shared VGA constants, colour codes and the square bounce-step helper
// used by square_painter and square_mover.
package vga_pkg;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned TICK_LINE = 480;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb_t;

  typedef struct packed {
    dir_e       dir;
    logic [9:0] pos;
  } axis_t;

  localparam rgb_t COL_RED   = 8'hE0;
  localparam rgb_t COL_GREEN = 8'h1C;
  localparam rgb_t COL_BLUE  = 8'h03;
  localparam rgb_t COL_BLACK = 8'h00;

  localparam logic [9:0] SQ0_X  = 10'd0;
  localparam logic [9:0] SQ0_Y  = 10'd0;
  localparam dir_e       SQ0_DX = DIR_POS;
  localparam dir_e       SQ0_DY = DIR_POS;
  localparam logic [9:0] SQ1_X  = 10'd300;
  localparam logic [9:0] SQ1_Y  = 10'd200;
  localparam dir_e       SQ1_DX = DIR_NEG;
  localparam dir_e       SQ1_DY = DIR_POS;
  localparam logic [9:0] SQ2_X  = 10'd600;
  localparam logic [9:0] SQ2_Y  = 10'd440;
  localparam dir_e       SQ2_DX = DIR_NEG;
  localparam dir_e       SQ2_DY = DIR_NEG;

  // One axis step with clamp-and-reflect at 0 and lim; 11-bit sum so nothing wraps.
  function automatic axis_t axis_step(input logic [9:0] pos, input dir_e dir,
                                      input logic [9:0] speed, input logic [9:0] lim);
    axis_t      r;
    logic [10:0] sum;
    sum   = {1'b0, pos} + {1'b0, speed};
    r.pos = pos;
    r.dir = dir;
    if (dir == DIR_POS) begin
      if (sum >= {1'b0, lim}) begin
        r.pos = lim;
        r.dir = DIR_NEG;
      end else begin
        r.pos = sum[9:0];
      end
    end else begin
      if (pos <= speed) begin
        r.pos = '0;
        r.dir = DIR_POS;
      end else begin
        r.pos = pos - speed;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/square_painter_if.sv
// Pixel bus between the VGA timing generator side and the colour stage.
interface square_painter_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       blank;
  logic       hs_in;
  logic       vs_in;
  logic [2:0] RED;
  logic [2:0] GREEN;
  logic [1:0] BLUE;
  logic       HS;
  logic       VS;

  modport master (output x, y, blank, hs_in, vs_in,
                  input  RED, GREEN, BLUE, HS, VS);
  modport slave  (input  x, y, blank, hs_in, vs_in,
                  output RED, GREEN, BLUE, HS, VS);
endinterface

// File: rtl/square_mover.sv
// Position and direction of one bouncing square; steps once per enabled frame tick.
module square_mover
  import vga_pkg::*;
#(
  parameter int unsigned SQ_SIZE = 32,
  parameter int unsigned SPEED   = 2,
  parameter logic [9:0]  INIT_X  = 10'd0,
  parameter logic [9:0]  INIT_Y  = 10'd0,
  parameter dir_e        INIT_DX = DIR_POS,
  parameter dir_e        INIT_DY = DIR_POS
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       tick,
  input  logic       EN,
  output logic [9:0] px,
  output logic [9:0] py
);

  localparam logic [9:0] XMAX = 10'(H_ACTIVE - SQ_SIZE);
  localparam logic [9:0] YMAX = 10'(V_ACTIVE - SQ_SIZE);
  localparam logic [9:0] SPD  = 10'(SPEED);

  dir_e  dx, dy;
  axis_t nx, ny;

  always_comb begin
    nx = axis_step(px, dx, SPD, XMAX);
    ny = axis_step(py, dy, SPD, YMAX);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      px <= INIT_X;
      py <= INIT_Y;
      dx <= INIT_DX;
      dy <= INIT_DY;
    end else if (tick && EN) begin
      px <= nx.pos;
      py <= ny.pos;
      dx <= nx.dir;
      dy <= ny.dir;
    end
  end

endmodule

// File: rtl/square_painter.sv
// Colour stage behind the VGA timing generator: three bouncing squares,
// two-stage pixel pipeline with matching sync delay.
module square_painter
  import vga_pkg::*;
#(
  parameter int unsigned SQ_SIZE = 32,
  parameter int unsigned SPEED   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  square_painter_if.slave  vga
);

  localparam logic [9:0] TICK_Y = 10'(TICK_LINE);

  logic [9:0] x_s1, y_s1;
  logic       blank_s1, hs_s1, vs_s1;
  logic       tick;
  logic [9:0] px [3];
  logic [9:0] py [3];
  logic [2:0] hit;
  rgb_t       pix, rgb_q;
  logic       hs_q, vs_q;

  function automatic logic in_square(input logic [9:0] cx, input logic [9:0] cy,
                                     input logic [9:0] sx, input logic [9:0] sy);
    return ({1'b0, cx} >= {1'b0, sx}) && ({1'b0, cx} < {1'b0, sx} + 11'(SQ_SIZE)) &&
           ({1'b0, cy} >= {1'b0, sy}) && ({1'b0, cy} < {1'b0, sy} + 11'(SQ_SIZE));
  endfunction

  // Tick on the first cycle of line 480; stage-1 y doubles as the previous-y register.
  assign tick = (y_s1 != TICK_Y) && (vga.y == TICK_Y);

  square_mover #(.SQ_SIZE(SQ_SIZE), .SPEED(SPEED), .INIT_X(SQ0_X), .INIT_Y(SQ0_Y),
                 .INIT_DX(SQ0_DX), .INIT_DY(SQ0_DY))
    u_sq0 (.CLK(CLK), .RST(RST), .tick(tick), .EN(EN), .px(px[0]), .py(py[0]));

  square_mover #(.SQ_SIZE(SQ_SIZE), .SPEED(SPEED), .INIT_X(SQ1_X), .INIT_Y(SQ1_Y),
                 .INIT_DX(SQ1_DX), .INIT_DY(SQ1_DY))
    u_sq1 (.CLK(CLK), .RST(RST), .tick(tick), .EN(EN), .px(px[1]), .py(py[1]));

  square_mover #(.SQ_SIZE(SQ_SIZE), .SPEED(SPEED), .INIT_X(SQ2_X), .INIT_Y(SQ2_Y),
                 .INIT_DX(SQ2_DX), .INIT_DY(SQ2_DY))
    u_sq2 (.CLK(CLK), .RST(RST), .tick(tick), .EN(EN), .px(px[2]), .py(py[2]));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_s1     <= '0;
      y_s1     <= '0;
      blank_s1 <= 1'b0;
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
    end else begin
      x_s1     <= vga.x;
      y_s1     <= vga.y;
      blank_s1 <= vga.blank;
      hs_s1    <= vga.hs_in;
      vs_s1    <= vga.vs_in;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      hit[i] = in_square(x_s1, y_s1, px[i], py[i]);
    end
  end

  always_comb begin
    pix = COL_BLACK;
    if (!blank_s1) begin
      if (hit[0])      pix = COL_RED;
      else if (hit[1]) pix = COL_GREEN;
      else if (hit[2]) pix = COL_BLUE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rgb_q <= COL_BLACK;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else begin
      rgb_q <= pix;
      hs_q  <= hs_s1;
      vs_q  <= vs_s1;
    end
  end

  assign vga.RED   = rgb_q.r;
  assign vga.GREEN = rgb_q.g;
  assign vga.BLUE  = rgb_q.b;
  assign vga.HS    = hs_q;
  assign vga.VS    = vs_q;

endmodule

// File: tb/tb_square_painter.sv
// Self-checking bench for square_painter against a behavioural bounce/colour model.
module tb_square_painter;

  localparam int SQ  = 32;
  localparam int SPD = 2;
  localparam int XMX = 640 - SQ;
  localparam int YMX = 480 - SQ;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic EN  = 1'b0;

  square_painter_if vga();

  square_painter #(.SQ_SIZE(SQ), .SPEED(SPD)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .vga(vga)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: positions, direction (1 = negative) and colour per square.
  int         mx [3];
  int         my [3];
  bit         mdx[3];
  bit         mdy[3];
  logic [7:0] mcol[3];
  int         ticks_done;

  task automatic model_reset();
    mx  = '{0, 300, 600};
    my  = '{0, 200, 440};
    mdx = '{0, 1, 1};
    mdy = '{0, 0, 1};
    mcol = '{8'b111_000_00, 8'b000_111_00, 8'b000_000_11};
    ticks_done = 0;
  endtask

  task automatic model_tick();
    int np;
    for (int i = 0; i < 3; i++) begin
      np = mdx[i] ? mx[i] - SPD : mx[i] + SPD;
      if (np >= XMX) begin np = XMX; mdx[i] = 1; end
      else if (np <= 0) begin np = 0; mdx[i] = 0; end
      mx[i] = np;
      np = mdy[i] ? my[i] - SPD : my[i] + SPD;
      if (np >= YMX) begin np = YMX; mdy[i] = 1; end
      else if (np <= 0) begin np = 0; mdy[i] = 0; end
      my[i] = np;
    end
    ticks_done++;
  endtask

  function automatic logic [7:0] model_rgb(input int xx, input int yy, input bit bl);
    if (bl) return 8'h00;
    for (int i = 0; i < 3; i++)
      if (xx >= mx[i] && xx < mx[i] + SQ && yy >= my[i] && yy < my[i] + SQ) return mcol[i];
    return 8'h00;
  endfunction

  // Presents one pixel and returns the colour that comes out two cycles later.
  task automatic show(input int xx, input int yy, input bit bl, output logic [7:0] rgb);
    vga.x     = 10'(xx);
    vga.y     = 10'(yy);
    vga.blank = bl;
    @(posedge CLK);
    @(posedge CLK);
    #1 rgb = {vga.RED, vga.GREEN, vga.BLUE};
  endtask

  task automatic do_tick(input bit en);
    vga.blank = 1'b1;
    vga.y     = 10'd479;
    @(posedge CLK); #1;
    vga.y = 10'd480;
    EN    = en;
    @(posedge CLK); #1;
    if (en) model_tick();
    EN    = 1'b0;
    vga.y = 10'd479;
  endtask

  task automatic apply_reset();
    RST       = 1'b1;
    vga.y     = '0;
    vga.blank = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [7:0] rgb;
    RST = 1'b1;
    vga.x = '0; vga.y = '0; vga.blank = 1'b1; vga.hs_in = 1'b1; vga.vs_in = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++;
    if ({vga.RED, vga.GREEN, vga.BLUE} !== 8'h00) begin
      n_fail++; $display("FAIL reset_rgb got %h want 00", {vga.RED, vga.GREEN, vga.BLUE});
    end
    n_checks++;
    if (vga.HS !== 1'b1 || vga.VS !== 1'b1) begin
      n_fail++; $display("FAIL reset_sync got HS=%b VS=%b want 1 1", vga.HS, vga.VS);
    end
    RST = 1'b0;
    model_reset();
    show(10, 10, 1'b1, rgb);
    n_checks++;
    if (rgb !== 8'h00) begin n_fail++; $display("FAIL blank_after_reset got %h want 00", rgb); end
    vga.hs_in = 1'b0;
    vga.vs_in = 1'b0;
    @(posedge CLK); #1;
    n_checks++;
    if (vga.HS !== 1'b1 || vga.VS !== 1'b1) begin
      n_fail++; $display("FAIL sync_t1 got HS=%b VS=%b want 1 1", vga.HS, vga.VS);
    end
    vga.hs_in = 1'b1;
    vga.vs_in = 1'b1;
    @(posedge CLK); #1;
    n_checks++;
    if (vga.HS !== 1'b0 || vga.VS !== 1'b0) begin
      n_fail++; $display("FAIL sync_t2 got HS=%b VS=%b want 0 0", vga.HS, vga.VS);
    end
    @(posedge CLK); #1;
    n_checks++;
    if (vga.HS !== 1'b1 || vga.VS !== 1'b1) begin
      n_fail++; $display("FAIL sync_t3 got HS=%b VS=%b want 1 1", vga.HS, vga.VS);
    end
  endtask

  task automatic test_draw();
    logic [7:0] rgb;
    int pts[5][2] = '{'{5, 5}, '{32, 5}, '{31, 31}, '{300, 200}, '{600, 440}};
    for (int i = 0; i < 5; i++) begin
      show(pts[i][0], pts[i][1], 1'b0, rgb);
      n_checks++;
      if (rgb !== model_rgb(pts[i][0], pts[i][1], 1'b0)) begin
        n_fail++;
        $display("FAIL draw(%0d,%0d) got %h want %h", pts[i][0], pts[i][1], rgb,
                 model_rgb(pts[i][0], pts[i][1], 1'b0));
      end
    end
  endtask

  task automatic test_motion();
    logic [7:0] rgb;
    int pts[3][2] = '{'{0, 0}, '{1, 1}, '{33, 33}};
    do_tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      show(pts[i][0], pts[i][1], 1'b0, rgb);
      n_checks++;
      if (rgb !== model_rgb(pts[i][0], pts[i][1], 1'b0)) begin
        n_fail++;
        $display("FAIL frozen(%0d,%0d) got %h want %h", pts[i][0], pts[i][1], rgb,
                 model_rgb(pts[i][0], pts[i][1], 1'b0));
      end
    end
    do_tick(1'b1);
    for (int i = 0; i < 3; i++) begin
      show(pts[i][0], pts[i][1], 1'b0, rgb);
      n_checks++;
      if (rgb !== model_rgb(pts[i][0], pts[i][1], 1'b0)) begin
        n_fail++;
        $display("FAIL moved(%0d,%0d) got %h want %h", pts[i][0], pts[i][1], rgb,
                 model_rgb(pts[i][0], pts[i][1], 1'b0));
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [7:0] rgb;
    int xx, yy, s;
    bit bl;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(1, 0) == 1) begin
        s  = int'($urandom_range(2, 0));
        xx = mx[s] + int'($urandom_range(SQ + 7, 0)) - 4;
        yy = my[s] + int'($urandom_range(SQ + 7, 0)) - 4;
      end else begin
        xx = int'($urandom_range(639, 0));
        yy = int'($urandom_range(479, 0));
      end
      if (xx < 0) xx = 0;
      if (xx > 639) xx = 639;
      if (yy < 0) yy = 0;
      if (yy > 479) yy = 479;
      bl = ($urandom_range(3, 0) == 0);
      show(xx, yy, bl, rgb);
      n_checks++;
      if (rgb !== model_rgb(xx, yy, bl)) begin
        n_fail++;
        $display("FAIL random(%0d,%0d,b=%0d) got %h want %h", xx, yy, bl, rgb, model_rgb(xx, yy, bl));
      end
    end
  endtask

  task automatic check_row(input string tag, input int xs[4], input int yy);
    logic [7:0] rgb;
    for (int i = 0; i < 4; i++) begin
      show(xs[i], yy, 1'b0, rgb);
      n_checks++;
      if (rgb !== model_rgb(xs[i], yy, 1'b0)) begin
        n_fail++;
        $display("FAIL %s(%0d,%0d) after %0d ticks got %h want %h", tag, xs[i], yy, ticks_done,
                 rgb, model_rgb(xs[i], yy, 1'b0));
      end
    end
  endtask

  task automatic test_bounce();
    apply_reset();
    while (ticks_done < 224) do_tick(1'b1);
    check_row("bounce_y224", '{447, 448, 479, 480}, 448);
    check_row("bounce_y224b", '{447, 448, 479, 480}, 447);
    do_tick(1'b1);
    check_row("bounce_y225", '{449, 450, 481, 482}, 446);
    while (ticks_done < 304) do_tick(1'b1);
    check_row("bounce_x304", '{606, 607, 608, 639}, my[0]);
    do_tick(1'b1);
    check_row("bounce_x305", '{605, 606, 637, 638}, my[0]);
  endtask

  task automatic test_overlap();
    logic [7:0] rgb;
    int  ox, oy, budget;
    bit  found;
    apply_reset();
    found  = 0;
    budget = 0;
    while (!found && budget < 6000) begin
      do_tick(1'b1);
      budget++;
      found = (mx[0] - mx[1] < SQ) && (mx[1] - mx[0] < SQ) &&
              (my[0] - my[1] < SQ) && (my[1] - my[0] < SQ);
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL overlap_search got none want overlap within 6000 ticks");
      return;
    end
    ox = (mx[0] > mx[1]) ? mx[0] : mx[1];
    oy = (my[0] > my[1]) ? my[0] : my[1];
    show(ox, oy, 1'b0, rgb);
    n_checks++;
    if (rgb !== 8'hE0) begin
      n_fail++; $display("FAIL overlap(%0d,%0d) got %h want e0", ox, oy, rgb);
    end
    show(ox, oy, 1'b1, rgb);
    n_checks++;
    if (rgb !== 8'h00) begin
      n_fail++; $display("FAIL overlap_blank(%0d,%0d) got %h want 00", ox, oy, rgb);
    end
    test_random(20);
  endtask

  task automatic test_async_reset();
    logic [7:0] rgb;
    vga.hs_in = 1'b0;
    vga.vs_in = 1'b0;
    show(mx[0], my[0], 1'b0, rgb);
    n_checks++;
    if (rgb !== 8'hE0 || vga.HS !== 1'b0) begin
      n_fail++; $display("FAIL pre_reset got rgb=%h HS=%b want e0 0", rgb, vga.HS);
    end
    #3 RST = 1'b1;
    #1;
    n_checks++;
    if ({vga.RED, vga.GREEN, vga.BLUE} !== 8'h00 || vga.HS !== 1'b1 || vga.VS !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got rgb=%h HS=%b VS=%b want 00 1 1",
               {vga.RED, vga.GREEN, vga.BLUE}, vga.HS, vga.VS);
    end
    vga.hs_in = 1'b1;
    vga.vs_in = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    model_reset();
    show(600, 440, 1'b0, rgb);
    n_checks++;
    if (rgb !== 8'h03) begin n_fail++; $display("FAIL post_reset_sq2 got %h want 03", rgb); end
    show(0, 0, 1'b0, rgb);
    n_checks++;
    if (rgb !== 8'hE0) begin n_fail++; $display("FAIL post_reset_sq0 got %h want e0", rgb); end
    test_random(20);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_draw();
    test_motion();
    test_random(40);
    test_bounce();
    test_random(30);
    test_overlap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/square_painter.md
# square_painter

Pixel-colour stage placed directly downstream of the VGA timing generator. Consumes the generator's active-area coordinates `x`/`y`, `blank`, `HS` and `VS`. Animates three solid squares that bounce inside the 640x480 active area, moving once per frame. Drives 8-bit RGB together with sync outputs delayed to match the colour pipeline.

## Interface
Parameters:
- `SQ_SIZE`, 32: edge length of every square in pixels (1..128).
- `SPEED`, 2: pixels moved per frame on each axis (1..15, must be < `SQ_SIZE`).

Ports:
- `CLK` in 1: pixel clock, the same clock as the timing generator.
- `RST` in 1: reset, asynchronous, active-high.
- `x` in 10: active-area column 0..639, valid when `blank`=0.
- `y` in 10: line counter 0..524.
- `blank` in 1: 1 = outside active area.
- `hs_in` in 1: horizontal sync from the timing generator, active-low.
- `vs_in` in 1: vertical sync from the timing generator, active-low.
- `EN` in 1: motion enable; 0 freezes all squares, but drawing continues.
- `RED` out 3: red output.
- `GREEN` out 3: green output.
- `BLUE` out 2: blue output.
- `HS` out 1: `hs_in` delayed 2 cycles.
- `VS` out 1: `vs_in` delayed 2 cycles.

## Operation
- **Per-square state:** `px`, `py` (10-bit unsigned, top-left corner) and direction flags `dx_neg`, `dy_neg`.
- **Initial state, also applied by reset:**
  - sq0: (0,0), dx+, dy+, red (RED=7, GREEN=0, BLUE=0).
  - sq1: (300,200), dx−, dy+, green (RED=0, GREEN=7, BLUE=0).
  - sq2: (600,440), dx−, dy−, blue (RED=0, GREEN=0, BLUE=3).
- **Frame tick:** asserted for one cycle on the first cycle with `y`==480, i.e. registered `y_d`!=480 and `y`==480. All position updates happen only on a tick with `EN`=1, which is inside vertical blanking, so no tearing.
- **Axis update, x shown; y is identical with limit `YMAX`=480−`SQ_SIZE`, `XMAX`=640−`SQ_SIZE`:**
  - moving +: if `px`+`SPEED` >= `XMAX`, then `px`<=`XMAX` and the flag flips to −; else `px`<=`px`+`SPEED`.
  - moving −: if `px` <= `SPEED`, then `px`<=0 and the flag flips to +; else `px`<=`px`−`SPEED`.
  - Compare using 11-bit sums so nothing wraps.
- **Hit test:** `x` >= `px` and `x` < `px`+`SQ_SIZE` (11-bit), and the same for `y`.
- **Priority where squares overlap:** sq0 > sq1 > sq2. No hit gives background black (all zero).
- **Blanking:** `blank`=1 forces RGB to 0 regardless of any hit.
- **Reset mid-frame:** all state returns to the initial values immediately and outputs go to 0. Drawing resumes on the next cycle after `RST` falls, using the initial positions.

## Timing
- **Reset values:** RED=0, GREEN=0, BLUE=0; HS=1, VS=1 (inactive); all pipeline registers 0 except sync stages, which are 1.
- **Pipeline:**
  - Stage 1 registers `x`, `y`, `blank`, `hs_in`, `vs_in`.
  - Stage 2 computes the hits from stage-1 values and registers RGB plus the syncs.
  - Latency is exactly 2 CLK cycles from input to RGB/HS/VS, with throughput of one pixel per cycle.
- **Position update timing:** on a tick, position registers update at the end of the tick cycle. Pixels already in the pipeline are all blanked, so the update is never visible mid-frame.
- **Tick with `EN`=0:** ignored, no state change. `EN` is sampled only on the tick cycle.
- **Tick during reset:** ignored.

## Structure
- **Shared package `vga_pkg`:**
  - `H_ACTIVE`=640, `V_ACTIVE`=480, `TICK_LINE`=480.
  - Initial positions/directions for the three squares.
  - 8-bit colour constants `COL_RED`, `COL_GREEN`, `COL_BLUE`, `COL_BLACK`.
- **Sub-module `square_mover`:** one instance per square. Inputs are `CLK`, `RST`, `tick`, `EN`; parameters are the initial position/direction and `SQ_SIZE`/`SPEED`; outputs are `px`, `py`. It holds the bounce logic.
- **Top level:** holds tick detection, the hit/priority mux and the 2-stage pipeline.

## Test plan
- **Reset hold, then release with `blank`=1:** outputs RGB=0, HS=1, VS=1. `hs_in`=0 at cycle t gives `HS`=0 at t+2.
- **Pixel draw:** present `x`=5, `y`=5, `blank`=0 → RED=7, GREEN=0, BLUE=0 at t+2. `x`=32, `y`=5 → black (edge is exclusive).
- **Motion:** one tick with `EN`=1 → sq0 at (2,2). Pixel (1,1) becomes black and pixel (33,33) red. Same tick with `EN`=0 → sq0 stays at (0,0).
- **Bounce:** after 224 ticks sq0 is at (448,448), dy flips. Tick 225 → (450,446). After 304 ticks x=608 and dx flips; tick 305 → x=606.
- **Overlap:** force sq0 and sq1 onto the same pixel by running ticks until they intersect → RGB is red only. Run with `blank`=1 over a hit pixel → 0.
- **Async reset mid-frame:** assert `RST` between clock edges → outputs 0 before the next edge. After release, squares are back at their initial positions (sq2 at 600,440).
